// File: rtl/spi_cfg_pkg.sv
// Shared types and constants for the SPI configuration sequencer.
// Entry layout is {rw, addr, data} with rw = 1 meaning a register write.
package spi_cfg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
    localparam logic [1:0] ERR_MISMATCH = 2'd2;

    localparam int DATA_LSB = 0;

    function automatic int rw_bit(input int addr_w, input int data_w);
        return addr_w + data_w;
    endfunction

    function automatic int addr_lsb(input int data_w);
        return data_w;
    endfunction

endpackage

// File: rtl/spi_cfg_table.sv
// Entry table: one synchronous write port and one registered read port.
// The read register doubles as the command word presented to the SPI master.
module spi_cfg_table
    import spi_cfg_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int WIDTH = 22
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are deliberately not reset so the array can map to RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/spi_cfg_sequencer.sv
// Table-driven SPI configuration sequencer: walks entries 0..len-1 on start.
// Define SPI_CFG_READBACK_CHECK_EN to compare read data against the entry data field.
module spi_cfg_sequencer
    import spi_cfg_pkg::*;
#(
    parameter int ADDR_W      = 13,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 32,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        tbl_wr_en,
    input  logic [$clog2(DEPTH)-1:0]    tbl_wr_idx,
    input  logic [ADDR_W+DATA_W:0]      tbl_wr_data,
    input  logic [$clog2(DEPTH):0]      seq_len,
    input  logic                        start,
    output logic                        busy,
    output logic                        seq_done,
    output logic                        err,
    output logic [1:0]                  err_code,
    output logic [$clog2(DEPTH)-1:0]    err_idx,
    output logic                        cmd_valid,
    input  logic                        cmd_ready,
    output logic [ADDR_W+DATA_W:0]      cmd_word,
    input  logic                        spi_done,
    input  logic [DATA_W-1:0]           spi_rd_data,
    output logic                        rd_valid,
    output logic [DATA_W-1:0]           rd_data,
    output logic [$clog2(DEPTH)-1:0]    rd_idx
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int LEN_W = IDX_W + 1;
    localparam int ENT_W = 1 + ADDR_W + DATA_W;
    localparam int RW    = rw_bit(ADDR_W, DATA_W);
    localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(DEPTH);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [LEN_W-1:0] len;
    logic [TMR_W-1:0] timer;
    logic             tbl_rd_en;
    logic             is_read;
    logic             rd_bad;
    logic             last_entry;

    assign tbl_rd_en  = (state == S_FETCH);
    assign is_read    = ~cmd_word[RW];
    assign last_entry = ({1'b0, idx} == (len - LEN_W'(1)));

`ifdef SPI_CFG_READBACK_CHECK_EN
    assign rd_bad = is_read && (spi_rd_data != cmd_word[DATA_LSB +: DATA_W]);
`else
    assign rd_bad = 1'b0;
`endif

    spi_cfg_table #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_table (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (tbl_wr_en && (state == S_IDLE)),
        .wr_idx  (tbl_wr_idx),
        .wr_data (tbl_wr_data),
        .rd_en   (tbl_rd_en),
        .rd_idx  (idx),
        .rd_data (cmd_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            len       <= '0;
            timer     <= '0;
            busy      <= 1'b0;
            seq_done  <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            err_idx   <= '0;
            cmd_valid <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            rd_idx    <= '0;
        end else begin
            seq_done <= 1'b0;
            rd_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx      <= '0;
                        len      <= (seq_len > DEPTH_LEN) ? DEPTH_LEN : seq_len;
                        err      <= 1'b0;
                        err_code <= ERR_NONE;
                        if (seq_len == '0) begin
                            seq_done <= 1'b1;
                        end else begin
                            busy  <= 1'b1;
                            state <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    cmd_valid <= 1'b1;
                    state     <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        timer     <= '0;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A completion in the final timer cycle still wins over the timeout.
                    if (spi_done) begin
                        if (is_read) begin
                            rd_valid <= 1'b1;
                            rd_data  <= spi_rd_data;
                            rd_idx   <= idx;
                        end
                        if (rd_bad) begin
                            err      <= 1'b1;
                            err_code <= ERR_MISMATCH;
                            err_idx  <= idx;
                            busy     <= 1'b0;
                            state    <= S_ERR;
                        end else begin
                            state <= S_NEXT;
                        end
                    end else if (timer == TMR_LAST) begin
                        err      <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                        err_idx  <= idx;
                        busy     <= 1'b0;
                        state    <= S_ERR;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                S_NEXT: begin
                    if (last_entry) begin
                        seq_done <= 1'b1;
                        busy     <= 1'b0;
                        state    <= S_DONE;
                    end else begin
                        idx   <= idx + IDX_W'(1);
                        state <= S_FETCH;
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// Randomised bench for spi_cfg_sequencer with a behavioural SPI-master responder
// and a transaction-level model of the expected command/read/outcome stream.
module tb_spi_cfg_sequencer;

    localparam int ADDR_W      = 13;
    localparam int DATA_W      = 8;
    localparam int DEPTH       = 8;
    localparam int TIMEOUT_CYC = 16;
    localparam int IDX_W       = $clog2(DEPTH);
    localparam int LEN_W       = IDX_W + 1;
    localparam int EW          = 1 + ADDR_W + DATA_W;
`ifdef SPI_CFG_READBACK_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              tbl_wr_en;
    logic [IDX_W-1:0]  tbl_wr_idx;
    logic [EW-1:0]     tbl_wr_data;
    logic [LEN_W-1:0]  seq_len;
    logic              start;
    logic              busy;
    logic              seq_done;
    logic              err;
    logic [1:0]        err_code;
    logic [IDX_W-1:0]  err_idx;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [EW-1:0]     cmd_word;
    logic              spi_done;
    logic [DATA_W-1:0] spi_rd_data;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [IDX_W-1:0]  rd_idx;

    spi_cfg_sequencer #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tbl_wr_en   (tbl_wr_en),
        .tbl_wr_idx  (tbl_wr_idx),
        .tbl_wr_data (tbl_wr_data),
        .seq_len     (seq_len),
        .start       (start),
        .busy        (busy),
        .seq_done    (seq_done),
        .err         (err),
        .err_code    (err_code),
        .err_idx     (err_idx),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_word    (cmd_word),
        .spi_done    (spi_done),
        .spi_rd_data (spi_rd_data),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_idx      (rd_idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Model state: table image, per-entry responder behaviour, expected outcome.
    logic [EW-1:0]     tbl_model [DEPTH];
    int                rdy_dly   [DEPTH];
    int                done_dly  [DEPTH];
    bit                drop      [DEPTH];
    logic [DATA_W-1:0] resp      [DEPTH];

    logic [EW-1:0]     hs_log[$];
    logic [IDX_W-1:0]  rdi_log[$];
    logic [DATA_W-1:0] rdd_log[$];
    int                hs_n;

    logic [EW-1:0]     exp_cmds[$];
    int                exp_rdi[$];
    logic [DATA_W-1:0] exp_rdd[$];
    int                exp_code;
    int                exp_eidx;

    function automatic logic [EW-1:0] mk_entry(input int rw, input int addr, input int data);
        return {1'(rw), ADDR_W'(addr), DATA_W'(data)};
    endfunction

    // SPI master responder: raise cmd_ready after rdy_dly valid cycles, spi_done after done_dly.
    int                rdy_cnt;
    int                done_cnt;
    int                cur;
    logic [EW-1:0]     held;
    initial begin
        cmd_ready = 1'b0; spi_done = 1'b0; spi_rd_data = '0;
        rdy_cnt = 0; done_cnt = 0; cur = 0; held = '0;
        forever begin
            @(negedge clk);
            cmd_ready = 1'b0;
            spi_done  = 1'b0;
            if (!rst_n) begin
                rdy_cnt = 0; done_cnt = 0;
            end else begin
                if (done_cnt > 0) begin
                    done_cnt--;
                    if (done_cnt == 0) begin
                        spi_done    = 1'b1;
                        spi_rd_data = resp[cur];
                    end
                end
                if (cmd_valid && hs_n < DEPTH) begin
                    if (rdy_cnt > 0) check_value("issue_stable", 32'(cmd_word), 32'(held));
                    else held = cmd_word;
                    if (rdy_cnt >= rdy_dly[hs_n]) begin
                        cmd_ready = 1'b1;
                        hs_log.push_back(cmd_word);
                        cur = hs_n;
                        if (!drop[hs_n]) done_cnt = done_dly[hs_n];
                        hs_n++;
                        rdy_cnt = 0;
                    end else begin
                        rdy_cnt++;
                    end
                end else begin
                    rdy_cnt = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && rd_valid) begin
            rdi_log.push_back(rd_idx);
            rdd_log.push_back(rd_data);
        end
    end

    task automatic write_tbl(input int idx, input logic [EW-1:0] data);
        @(negedge clk);
        tbl_wr_en = 1'b1; tbl_wr_idx = IDX_W'(idx); tbl_wr_data = data;
        @(negedge clk);
        tbl_wr_en = 1'b0;
        tbl_model[idx] = data;
    endtask

    task automatic set_timing(input int r, input int d);
        for (int k = 0; k < DEPTH; k++) begin
            rdy_dly[k] = r; done_dly[k] = d; drop[k] = 1'b0;
            resp[k] = tbl_model[k][DATA_W-1:0];
        end
    endtask

    // Expected transaction stream derived from the table and responder settings.
    task automatic build_expect(input int slen);
        int len;
        logic [EW-1:0] e;
        len = (slen > DEPTH) ? DEPTH : slen;
        exp_cmds.delete(); exp_rdi.delete(); exp_rdd.delete();
        exp_code = 0; exp_eidx = 0;
        for (int i = 0; i < len; i++) begin
            e = tbl_model[i];
            exp_cmds.push_back(e);
            if (drop[i] || done_dly[i] > TIMEOUT_CYC) begin
                exp_code = 1; exp_eidx = i; break;
            end
            if (!e[EW-1]) begin
                exp_rdi.push_back(i);
                exp_rdd.push_back(resp[i]);
                if (CHECK_EN && resp[i] != e[DATA_W-1:0]) begin
                    exp_code = 2; exp_eidx = i; break;
                end
            end
        end
    endtask

    task automatic run_seq(input int slen, input bit co_wr, input int co_idx,
                           input logic [EW-1:0] co_data, input bit poke);
        int guard;
        int n_done;
        bit got_err;
        if (co_wr) tbl_model[co_idx] = co_data;
        build_expect(slen);
        hs_log.delete(); rdi_log.delete(); rdd_log.delete(); hs_n = 0;
        @(negedge clk);
        start = 1'b1; seq_len = LEN_W'(slen);
        if (co_wr) begin
            tbl_wr_en = 1'b1; tbl_wr_idx = IDX_W'(co_idx); tbl_wr_data = co_data;
        end
        @(negedge clk);
        start = 1'b0; tbl_wr_en = 1'b0;
        if (slen == 0) begin
            check_value("len0_done", 32'(seq_done), 1);
            check_value("len0_valid", 32'(cmd_valid), 0);
        end else begin
            check_value("busy_rise", 32'(busy), 1);
        end
        n_done = 0; got_err = 1'b0; guard = 0;
        while (guard < 3000) begin
            if (seq_done) n_done++;
            if (err) got_err = 1'b1;
            if (n_done > 0 || got_err) break;
            start     = poke && (guard == 3);
            tbl_wr_en = poke && (guard == 3);
            tbl_wr_idx = '0; tbl_wr_data = ~tbl_model[0];
            @(negedge clk);
            guard++;
        end
        start = 1'b0; tbl_wr_en = 1'b0;
        if (guard >= 3000) check_value("seq_bound", 0, 1);
        repeat (6) begin
            @(negedge clk);
            if (seq_done) n_done++;
        end
        check_value("n_cmds", hs_log.size(), exp_cmds.size());
        for (int i = 0; i < exp_cmds.size() && i < hs_log.size(); i++)
            check_value("cmd_word", 32'(hs_log[i]), 32'(exp_cmds[i]));
        check_value("n_reads", rdi_log.size(), exp_rdi.size());
        for (int i = 0; i < exp_rdi.size() && i < rdi_log.size(); i++) begin
            check_value("rd_idx", 32'(rdi_log[i]), exp_rdi[i]);
            check_value("rd_data", 32'(rdd_log[i]), 32'(exp_rdd[i]));
        end
        check_value("seq_done_cnt", n_done, (exp_code == 0) ? 1 : 0);
        check_value("err", 32'(err), (exp_code != 0) ? 1 : 0);
        check_value("err_code", 32'(err_code), exp_code);
        if (exp_code != 0) check_value("err_idx", 32'(err_idx), exp_eidx);
        check_value("busy_end", 32'(busy), 0);
        $display("seq len=%0d cmds=%0d reads=%0d done=%0d err_code=%0d err_idx=%0d",
                 slen, hs_log.size(), rdi_log.size(), n_done, err_code, err_idx);
    endtask

    initial begin
        int guard;
        rst_n = 1'b0; tbl_wr_en = 1'b0; tbl_wr_idx = '0; tbl_wr_data = '0;
        seq_len = '0; start = 1'b0; hs_n = 0;
        set_timing(0, 1);
        repeat (3) @(negedge clk);
        check_value("rst_busy", 32'(busy), 0);
        check_value("rst_seq_done", 32'(seq_done), 0);
        check_value("rst_err", 32'(err), 0);
        check_value("rst_cmd_valid", 32'(cmd_valid), 0);
        check_value("rst_rd_valid", 32'(rd_valid), 0);
        check_value("rst_err_code", 32'(err_code), 0);
        check_value("rst_err_idx", 32'(err_idx), 0);
        check_value("rst_cmd_word", 32'(cmd_word), 0);
        check_value("rst_rd_data", 32'(rd_data), 0);
        check_value("rst_rd_idx", 32'(rd_idx), 0);
        rst_n = 1'b1;

        for (int k = 0; k < DEPTH; k++)
            write_tbl(k, mk_entry(1, int'($urandom_range(0, 8191)), int'($urandom_range(0, 255))));

        // Basic three-entry run ending in a read.
        write_tbl(0, mk_entry(1, 'h000, 'h18));
        write_tbl(1, mk_entry(1, 'h005, 'h03));
        write_tbl(2, mk_entry(0, 'h005, 'h03));
        set_timing(2, 2);
        run_seq(3, 0, 0, '0, 0);

        // cmd_ready held off for 10 cycles.
        set_timing(10, 1);
        run_seq(1, 0, 0, '0, 0);

        // Entry 1 never completes: timeout.
        set_timing(1, 2); drop[1] = 1'b1;
        run_seq(3, 0, 0, '0, 0);

        // Timeout boundary: last legal cycle, then one past it.
        set_timing(0, TIMEOUT_CYC);
        run_seq(1, 0, 0, '0, 0);
        set_timing(0, TIMEOUT_CYC + 1);
        run_seq(1, 0, 0, '0, 0);

        // Read returning data that differs from the entry.
        write_tbl(0, mk_entry(0, 'h010, 'h01));
        set_timing(0, 1); resp[0] = 8'h05;
        run_seq(1, 0, 0, '0, 0);

        // Zero length and over-long length.
        set_timing(0, 1);
        run_seq(0, 0, 0, '0, 0);
        run_seq(DEPTH + 1, 0, 0, '0, 0);

        // start and table write while busy are ignored.
        set_timing(2, 3);
        run_seq(3, 0, 0, '0, 1);

        // Table write in the same cycle as start lands first.
        set_timing(0, 1);
        run_seq(2, 1, 0, mk_entry(1, 'h1AB, 'h5A), 0);

        // Reset while waiting for spi_done.
        set_timing(1, 3); drop[0] = 1'b1;
        hs_log.delete(); hs_n = 0;
        @(negedge clk); start = 1'b1; seq_len = LEN_W'(3);
        @(negedge clk); start = 1'b0;
        guard = 0;
        while (hs_log.size() == 0 && guard < 100) begin
            @(negedge clk); guard++;
        end
        check_value("rst_mid_hs", hs_log.size(), 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_value("mid_busy", 32'(busy), 0);
        check_value("mid_cmd_valid", 32'(cmd_valid), 0);
        check_value("mid_seq_done", 32'(seq_done), 0);
        check_value("mid_err", 32'(err), 0);
        check_value("mid_err_code", 32'(err_code), 0);
        check_value("mid_rd_valid", 32'(rd_valid), 0);
        check_value("mid_cmd_word", 32'(cmd_word), 0);
        @(negedge clk);
        rst_n = 1'b1; hs_log.delete(); hs_n = 0;
        repeat (10) @(negedge clk);
        check_value("no_reissue", hs_log.size(), 0);
        set_timing(1, 3);
        run_seq(3, 0, 0, '0, 0);

        // Randomised runs.
        for (int it = 0; it < 20; it++) begin
            int nw;
            nw = $urandom_range(0, 3);
            for (int k = 0; k < nw; k++)
                write_tbl(int'($urandom_range(0, DEPTH - 1)),
                          mk_entry(int'($urandom_range(0, 1)), int'($urandom_range(0, 8191)),
                                   int'($urandom_range(0, 255))));
            for (int k = 0; k < DEPTH; k++) begin
                rdy_dly[k]  = $urandom_range(0, 3);
                done_dly[k] = $urandom_range(1, 5);
                drop[k]     = ($urandom_range(0, 19) == 0);
                resp[k]     = tbl_model[k][DATA_W-1:0];
                if ($urandom_range(0, 9) == 0) resp[k] = DATA_W'($urandom);
                if ($urandom_range(0, 19) == 0) done_dly[k] = TIMEOUT_CYC + int'($urandom_range(0, 1));
            end
            run_seq(int'($urandom_range(0, 2 * DEPTH - 1)), 0, 0, '0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
